// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks a fetch PC through a combinational ROM, buffers
// fetched words in a prefetch FIFO, handles redirect flushes and sticky fetch faults.
module fetch_sequencer #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        fault,
    output logic [63:0] fault_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [63:0] MEM_SIZE64 = 64'(MEM_SIZE);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        StFetch,
        StFault
    } state_e;

    state_e        state;
    logic [63:0]   fetch_pc;
    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   pc_mem    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic addr_bad;
    logic pop;
    logic push;

    assign addr_bad = (fetch_pc[1:0] != 2'b00) || ((fetch_pc + 64'd3) >= MEM_SIZE64);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push     = (state == StFetch) && !addr_bad && ((count < DEPTH_C) || pop);

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : 64'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StFetch;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault    <= 1'b0;
            fault_pc <= 64'h0;
        end else if (redirect_valid) begin
            // Redirect wins over any pop/push and any pending fault.
            state    <= StFetch;
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fault    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if ((state == StFetch) && addr_bad) begin
                state    <= StFault;
                fault    <= 1'b1;
                fault_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !redirect_valid) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_instr;
        end
    end

endmodule
